// File: rtl/ulpi_reg_sequencer.sv
// ulpi_reg_sequencer
// Command sequencer and arbiter in front of the ULPI register-access engine.
// After reset it writes each init register to the PHY, reads it back and
// compares. Entries that keep mismatching are retried a bounded number of
// times. After that the engine is handed to the host config port, one
// register transaction at a time. Everything runs in the clk_ext
// (PHY CLKOUT) domain.
//
// Ports
//   clk_ext     in   sole clock
//   rst         in   synchronous active-high reset
//   init_done   out  init sequence finished (pass or fail), sticky
//   init_err    out  some init entry failed (retries exhausted or timeout), sticky
//   cfg_req     in   host request, held until cfg_ack
//   cfg_we      in   1 = write, 0 = read
//   cfg_addr    in   host register address
//   cfg_wdata   in   host write data
//   cfg_ack     out  one-cycle completion pulse
//   cfg_rdata   out  read data, updated on read acks only
//   cfg_err     out  transaction timed out, valid with cfg_ack
//   ulpi_wd     out  one-cycle write strobe to the engine
//   ulpi_rd     out  one-cycle read strobe to the engine
//   ulpi_addr   out  register address, stable from strobe until busy falls
//   ulpi_wdata  out  write data, same hold rule
//   ulpi_rdata  in   engine read result, valid on the cycle busy falls
//   ulpi_busy   in   engine busy
module ulpi_reg_sequencer #(
   parameter int          INIT_LEN  = 3,
   parameter logic [23:0] INIT_ADDR = {6'h00, 6'h0A, 6'h07, 6'h04},
   parameter logic [31:0] INIT_DATA = {8'h00, 8'h00, 8'h00, 8'h48},
   parameter int          MAX_RETRY = 2,
   parameter int          TIMEOUT   = 255
) (
   input  logic       clk_ext,
   input  logic       rst,
   output logic       init_done,
   output logic       init_err,
   input  logic       cfg_req,
   input  logic       cfg_we,
   input  logic [5:0] cfg_addr,
   input  logic [7:0] cfg_wdata,
   output logic       cfg_ack,
   output logic [7:0] cfg_rdata,
   output logic       cfg_err,
   output logic       ulpi_wd,
   output logic       ulpi_rd,
   output logic [5:0] ulpi_addr,
   output logic [7:0] ulpi_wdata,
   input  logic [7:0] ulpi_rdata,
   input  logic       ulpi_busy
);

   typedef enum logic [2:0] {
      INIT_ISSUE, INIT_WAIT, RB_ISSUE, RB_WAIT, READY, HOST_WAIT
   } state_t;

   state_t      state, state_nx;
   logic [1:0]  idx;
   logic [3:0]  retry;
   logic [7:0]  tmo_cnt;
   logic        busy_seen;
   logic        host_we;
   logic [5:0]  host_addr;
   logic [7:0]  host_wdata;

   logic [5:0]  init_addr_cur;
   logic [7:0]  init_data_cur;
   logic        waiting, strobe, accept;
   logic        txn_done, txn_tmo;
   logic        last_entry, rb_match, retry_left;
   logic        entry_retry, entry_end, entry_fail;

   assign init_addr_cur = INIT_ADDR[6*int'(idx) +: 6];
   assign init_data_cur = INIT_DATA[8*int'(idx) +: 8];

   assign waiting    = (state == INIT_WAIT) || (state == RB_WAIT) || (state == HOST_WAIT);
   assign strobe     = ulpi_wd | ulpi_rd;
   // The ack cycle itself never starts a new transaction, so a held cfg_req
   // is only seen again the cycle after cfg_ack.
   assign accept     = (state == READY) && cfg_req && !ulpi_busy && !cfg_ack;

   // Completion needs busy to have been seen high since the strobe; an
   // engine that never raises busy runs into the timeout instead.
   assign txn_done   = waiting && busy_seen && !ulpi_busy;
   assign txn_tmo    = waiting && !txn_done && (tmo_cnt == 8'(TIMEOUT));

   assign last_entry = (idx == 2'(INIT_LEN - 1));
   assign rb_match   = (ulpi_rdata == init_data_cur);
   assign retry_left = (retry < 4'(MAX_RETRY));

   assign entry_retry = (state == RB_WAIT) && txn_done && !rb_match && retry_left;
   assign entry_end   = ((state == INIT_WAIT) && txn_tmo) ||
                        ((state == RB_WAIT) && (txn_tmo || (txn_done && (rb_match || !retry_left))));
   assign entry_fail  = entry_end && !((state == RB_WAIT) && txn_done && rb_match);

   // State register
   always_ff @(posedge clk_ext) begin
      if (rst) state <= INIT_ISSUE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         INIT_ISSUE: if (!ulpi_busy) state_nx = INIT_WAIT;
         INIT_WAIT: begin
            if (txn_done)       state_nx = RB_ISSUE;
            else if (entry_end) state_nx = last_entry ? READY : INIT_ISSUE;
         end
         RB_ISSUE:   if (!ulpi_busy) state_nx = RB_WAIT;
         RB_WAIT: begin
            if (entry_retry)    state_nx = INIT_ISSUE;
            else if (entry_end) state_nx = last_entry ? READY : INIT_ISSUE;
         end
         READY:      if (accept) state_nx = HOST_WAIT;
         HOST_WAIT:  if (txn_done || txn_tmo) state_nx = READY;
         default:    state_nx = INIT_ISSUE;
      endcase
   end

   // Engine-side outputs. Strobes are combinational so a host request can be
   // issued in the same cycle it is seen; rst forces everything low.
   always_comb begin
      ulpi_wd    = 1'b0;
      ulpi_rd    = 1'b0;
      ulpi_addr  = 6'h00;
      ulpi_wdata = 8'h00;
      if (!rst) begin
         case (state)
            INIT_ISSUE, INIT_WAIT: begin
               ulpi_addr  = init_addr_cur;
               ulpi_wdata = init_data_cur;
               ulpi_wd    = (state == INIT_ISSUE) && !ulpi_busy;
            end
            RB_ISSUE, RB_WAIT: begin
               ulpi_addr = init_addr_cur;
               ulpi_rd   = (state == RB_ISSUE) && !ulpi_busy;
            end
            READY: begin
               ulpi_addr  = cfg_addr;
               ulpi_wdata = cfg_wdata;
               ulpi_wd    = accept && cfg_we;
               ulpi_rd    = accept && !cfg_we;
            end
            HOST_WAIT: begin
               ulpi_addr  = host_addr;
               ulpi_wdata = host_wdata;
            end
            default: ;
         endcase
      end
   end

   // Entry bookkeeping, timeout tracking and host handshake
   always_ff @(posedge clk_ext) begin
      if (rst) begin
         idx        <= '0;
         retry      <= '0;
         tmo_cnt    <= '0;
         busy_seen  <= 1'b0;
         init_done  <= 1'b0;
         init_err   <= 1'b0;
         cfg_ack    <= 1'b0;
         cfg_err    <= 1'b0;
         cfg_rdata  <= '0;
         host_we    <= 1'b0;
         host_addr  <= '0;
         host_wdata <= '0;
      end else begin
         cfg_ack <= 1'b0;
         if (strobe) begin
            tmo_cnt   <= '0;
            busy_seen <= 1'b0;
         end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (ulpi_busy) busy_seen <= 1'b1;
         end
         if (entry_end) begin
            retry <= '0;
            if (entry_fail) init_err <= 1'b1;
            if (last_entry) init_done <= 1'b1;
            else            idx <= idx + 2'd1;
         end else if (entry_retry) begin
            retry <= retry + 4'd1;
         end
         if (accept) begin
            host_we    <= cfg_we;
            host_addr  <= cfg_addr;
            host_wdata <= cfg_wdata;
         end
         if ((state == HOST_WAIT) && (txn_done || txn_tmo)) begin
            cfg_ack <= 1'b1;
            cfg_err <= txn_tmo;
            if (txn_done && !host_we) cfg_rdata <= ulpi_rdata;
         end
      end
   end

endmodule
